// File: rtl/serial_pkg.sv
// Shared definitions for the serial feeder: FSM state encodings and counter widths.
package serial_pkg;

  // FSM state encodings. ST_GAP is kept distinct from the detector's A/B/C encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Width of the inter-word gap counter (GAP up to 15).
  localparam int GAP_W = 4;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out register. bit_out is a flop holding the bit currently on
// the line. On load it takes the first bit of the word, and the remaining bits wait
// in sr. Each shift moves the next bit into bit_out and back-fills sr with FILL_BIT.
// Once the word is exhausted, bit_out therefore settles on FILL_BIT by itself.
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit FILL_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic             bit_out
);

  logic [WIDTH-1:0] sr;
  logic             bit_q;

  // Load a new word (takes priority), or step to the next bit on shift.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr    <= '0;
      bit_q <= FILL_BIT;
    end else if (load) begin
      if (MSB_FIRST) begin
        bit_q <= load_data[WIDTH-1];
        sr    <= {load_data[WIDTH-2:0], FILL_BIT};
      end else begin
        bit_q <= load_data[0];
        sr    <= {FILL_BIT, load_data[WIDTH-1:1]};
      end
    end else if (shift) begin
      if (MSB_FIRST) begin
        bit_q <= sr[WIDTH-1];
        sr    <= {sr[WIDTH-2:0], FILL_BIT};
      end else begin
        bit_q <= sr[0];
        sr    <= {FILL_BIT, sr[WIDTH-1:1]};
      end
    end
  end

  assign bit_out = bit_q;

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the sequence detector input. Accepts words on a
// valid/ready handshake and emits them one bit per clock. An optional idle gap can
// follow each word. IDLE_BIT is driven whenever no data bit is on the line.
module serial_bit_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  logic [1:0]       state;
  logic [CNT_W-1:0] bit_cnt;   // index of the bit currently on ser_bit
  logic [GAP_W-1:0] gap_cnt;   // gap cycles already spent
  logic             last_bit;
  logic             accept;

  assign last_bit = (bit_cnt == BIT_LAST);

  // Ready in IDLE, and on the last bit of a word when words may run back-to-back.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      ST_IDLE:  in_ready = 1'b1;
      ST_SHIFT: in_ready = (GAP == 0) && last_bit;
      default:  in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign busy   = (state != ST_IDLE);

  // FSM, bit/gap counters and the registered ser_valid / word_done flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      ser_valid <= 1'b0;
      word_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_SHIFT;
            bit_cnt   <= '0;
            ser_valid <= 1'b1;
            word_done <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (!last_bit) begin
            bit_cnt   <= bit_cnt + 1'b1;
            // Raise word_done together with the last bit reaching the line.
            word_done <= (bit_cnt == BIT_LAST - 1'b1);
          end else begin
            word_done <= 1'b0;
            if (GAP > 0) begin
              state     <= ST_GAP;
              gap_cnt   <= '0;
              ser_valid <= 1'b0;
            end else if (accept) begin
              // Back-to-back word: the first bit follows with no bubble.
              bit_cnt   <= '0;
              ser_valid <= 1'b1;
            end else begin
              state     <= ST_IDLE;
              ser_valid <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          ser_valid <= 1'b0;
          word_done <= 1'b0;
        end
      endcase
    end
  end

  // The shifter runs on every SHIFT cycle. After the final shift of a word it holds IDLE_BIT.
  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .FILL_BIT  (IDLE_BIT)
  ) u_piso (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (in_data),
    .shift     (state == ST_SHIFT),
    .bit_out   (ser_bit)
  );

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder. Instance A: WIDTH=8, MSB first, no gap.
// Instance B: WIDTH=8, LSB first, GAP=3.
module tb_serial_bit_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic [7:0] in_data_a, in_data_b;
  logic       in_valid_a, in_valid_b;
  logic       in_ready_a, in_ready_b;
  logic       ser_bit_a, ser_bit_b;
  logic       ser_valid_a, ser_valid_b;
  logic       word_done_a, word_done_b;
  logic       busy_a, busy_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0), .IDLE_BIT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .ser_bit(ser_bit_a), .ser_valid(ser_valid_a), .word_done(word_done_a), .busy(busy_a)
  );

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(3), .IDLE_BIT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .ser_bit(ser_bit_b), .ser_valid(ser_valid_b), .word_done(word_done_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic b, input logic v, input logic wd, input logic bz);
    check({tag, ".bit"},  ser_bit_a,   b);
    check({tag, ".val"},  ser_valid_a, v);
    check({tag, ".done"}, word_done_a, wd);
    check({tag, ".busy"}, busy_a,      bz);
  endtask

  task automatic chk_b(input string tag, input logic b, input logic v, input logic wd, input logic bz);
    check({tag, ".bit"},  ser_bit_b,   b);
    check({tag, ".val"},  ser_valid_b, v);
    check({tag, ".done"}, word_done_b, wd);
    check({tag, ".busy"}, busy_b,      bz);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] w;

    // 1. Reset held for 3 cycles with in_valid high: nothing accepted, outputs idle.
    in_data_a  = 8'hD3; in_valid_a = 1'b1;
    in_data_b  = 8'h01; in_valid_b = 1'b1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_a($sformatf("t1.a.rst%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
      chk_b($sformatf("t1.b.rst%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1; in_valid_a = 1'b0; in_valid_b = 1'b0;
    step();
    chk_a("t1.a.rel", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_b("t1.b.rel", 1'b0, 1'b0, 1'b0, 1'b0);
    check("t1.a.rdy", in_ready_a, 1'b1);
    check("t1.b.rdy", in_ready_b, 1'b1);

    // 2. Single word 8'hD3, MSB first: 1,1,0,1,0,0,1,1.
    w = 8'hD3;
    in_data_a = w; in_valid_a = 1'b1;
    check("t2.rdy_pre", in_ready_a, 1'b1);
    step();
    in_valid_a = 1'b0; in_data_a = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk_a($sformatf("t2.b%0d", i), w[7-i], 1'b1, i == 7, 1'b1);
      check($sformatf("t2.rdy%0d", i), in_ready_a, i == 7);
      step();
    end
    chk_a("t2.end", 1'b0, 1'b0, 1'b0, 1'b0);
    check("t2.end.rdy", in_ready_a, 1'b1);

    // 3. Back-to-back 8'hFF then 8'h00 with in_valid held: 16 bits, no bubble.
    in_data_a = 8'hFF; in_valid_a = 1'b1;
    step();
    in_data_a = 8'h00;
    for (int i = 0; i < 16; i++) begin
      chk_a($sformatf("t3.b%0d", i), i < 8, 1'b1, (i == 7) || (i == 15), 1'b1);
      check($sformatf("t3.rdy%0d", i), in_ready_a, (i == 7) || (i == 15));
      if (i == 15) in_valid_a = 1'b0;
      step();
    end
    chk_a("t3.end", 1'b0, 1'b0, 1'b0, 1'b0);

    // 6. in_valid held (with a low pulse) through a word: only one load per handshake.
    w = 8'h5A;
    in_data_a = w; in_valid_a = 1'b1;
    step();
    in_data_a = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      in_valid_a = (i != 3);
      chk_a($sformatf("t6.w0b%0d", i), w[7-i], 1'b1, i == 7, 1'b1);
      check($sformatf("t6.rdy%0d", i), in_ready_a, i == 7);
      step();
    end
    in_valid_a = 1'b0; in_data_a = 8'h00;
    w = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      chk_a($sformatf("t6.w1b%0d", i), w[7-i], 1'b1, i == 7, 1'b1);
      step();
    end
    chk_a("t6.end", 1'b0, 1'b0, 1'b0, 1'b0);

    // 4. GAP=3, LSB first: 8'h01 then 8'h80 with in_valid held.
    in_data_b = 8'h01; in_valid_b = 1'b1;
    check("t4.rdy_pre", in_ready_b, 1'b1);
    step();
    in_data_b = 8'h80;
    for (int i = 0; i < 8; i++) begin
      chk_b($sformatf("t4.w0b%0d", i), i == 0, 1'b1, i == 7, 1'b1);
      check($sformatf("t4.w0rdy%0d", i), in_ready_b, 1'b0);
      step();
    end
    for (int g = 0; g < 3; g++) begin
      chk_b($sformatf("t4.gap%0d", g), 1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("t4.gaprdy%0d", g), in_ready_b, 1'b0);
      step();
    end
    chk_b("t4.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check("t4.idle.rdy", in_ready_b, 1'b1);
    step();
    in_valid_b = 1'b0; in_data_b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk_b($sformatf("t4.w1b%0d", i), i == 7, 1'b1, i == 7, 1'b1);
      step();
    end
    for (int g = 0; g < 3; g++) begin
      chk_b($sformatf("t4.gap2_%0d", g), 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end
    chk_b("t4.end", 1'b0, 1'b0, 1'b0, 1'b0);

    // 5. Reset after the 4th bit of 8'hAA aborts the word.
    w = 8'hAA;
    in_data_a = w; in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_a($sformatf("t5.b%0d", i), w[7-i], 1'b1, 1'b0, 1'b1);
      if (i < 3) step();
    end
    rst = 1'b0;
    step();
    chk_a("t5.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_a($sformatf("t5.post%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
